key_debounce_array: RTL and testbench
=====================================

Name: key_debounce_array

Overview:
Parametrised multi-channel push-button conditioner: synchronises, debounces and classifies N_KEYS raw button inputs in the clk domain (pixel clock in the video designs).
Per channel it outputs:
- a debounced level
- one-cycle press and release pulses
- a one-shot long-press pulse
- optional auto-repeat pulses while held
Sits between board pins and UI/control FSMs; replaces single-key, falling-edge-only debouncing.

Parameters:
N_KEYS, 4, number of independent key channels
ACTIVE_LOW, 1, 1: key_in pressed = 0; 0: pressed = 1 (applies to all channels)
DEBOUNCE_CYC, 65536, consecutive cycles a synchronised input must differ from the stable state before the state flips (>=2)
LONG_CYC, 2**24, cycles of continuous debounced press before key_long fires (>DEBOUNCE_CYC)
REPEAT_CYC, 2**22, period of key_repeat pulses after key_long while repeat enabled (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
key_in  in  N_KEYS  raw asynchronous button inputs, polarity per ACTIVE_LOW
repeat_en  in  N_KEYS  per-channel auto-repeat enable, synchronous to clk
key_level  out  N_KEYS  debounced state, 1 = pressed, independent of ACTIVE_LOW
key_press  out  N_KEYS  1-cycle pulse on debounced press
key_release  out  N_KEYS  1-cycle pulse on debounced release
key_long  out  N_KEYS  1-cycle pulse once per hold reaching LONG_CYC
key_repeat  out  N_KEYS  1-cycle pulses every REPEAT_CYC after key_long while held and repeat_en=1

Behaviour:
- Reset: sync flops = released level; stable state = released; all counters 0; all outputs 0. Reset mid-press → channel reports released; a still-held key is re-debounced and produces a fresh key_press.
- Input normalisation: p = key_in XOR ACTIVE_LOW, so internal 1 = pressed. Two-flop synchroniser per channel, s1 then s2.
- Debounce counter (width $clog2(DEBOUNCE_CYC)):
  - s2 == state → counter cleared.
  - s2 != state → counter increments.
  - On the cycle s2 != state and counter == DEBOUNCE_CYC-1: state <= s2, counter cleared.
  - Any single-cycle return to state clears the counter (no partial credit).
- Latency: key_in stable from edge k → key_level changes at edge k+2+DEBOUNCE_CYC (±1 for metastability resolution).
- key_press/key_release are registered and asserted in the same cycle key_level changes. Never both high. Never two consecutive cycles.
- Hold counter (width $clog2(LONG_CYC+1)):
  - Cleared while state = released and on the press transition.
  - Increments each cycle while pressed; saturates at LONG_CYC.
  - key_long pulses on the cycle the counter reaches LONG_CYC: exactly once per press.
- Repeat counter (width $clog2(REPEAT_CYC)):
  - Cleared when not in long-held state or repeat_en=0.
  - In long-held state with repeat_en=1: counts 0..REPEAT_CYC-1, wraps. key_repeat pulses on wrap, so first repeat comes REPEAT_CYC cycles after key_long.
  - repeat_en deasserted mid-hold: counter clears; re-assert restarts the full period.
- Release during long-held or repeat: key_release pulses; no further long/repeat pulses; hold and repeat counters clear.
- Release before LONG_CYC: no key_long.
- Channels fully independent; simultaneous events on several channels produce simultaneous pulses.

Decomposition:
- Package key_pkg: polarity constants KEY_PRESSED/KEY_RELEASED, and a function computing counter widths (clog2 with minimum 1).
- Sub-module key_debounce_chan: one channel covering sync, debounce, hold and repeat, scalar ports, same parameters minus N_KEYS.
- Top: generate loop of N_KEYS instances plus polarity XOR.

Test Plan (sim params: DEBOUNCE_CYC=8, LONG_CYC=40, REPEAT_CYC=10, N_KEYS=4, ACTIVE_LOW=1):
1. key_in[0] 1→0 held 60 cycles → key_level[0]=1 at edge 10 after the change; one key_press[0]; key_long[0] 40 cycles later; no key_repeat (repeat_en=0).
2. key_in[1] 0-glitches of 7 cycles separated by 1-cycle highs, repeated 5× → key_level[1] stays 0; no pulses.
3. repeat_en[2]=1, hold key 2 for 75 cycles after debounce → key_long, then key_repeat at +10, +20, +30; release → key_release, no further repeats.
4. Press keys 0 and 3 on the same edge → key_press[0] and key_press[3] in the same cycle; other channels 0.
5. Hold key 0; assert rst_n=0 for 3 cycles mid-hold; release reset with key still held → outputs 0 during reset; fresh key_press 10 cycles after reset release.
6. ACTIVE_LOW=0 build, key_in[0] 0→1 → key_level[0]=1 and key_press[0] after 10 cycles; key_in 1→0 → key_release[0].

Source files
------------

// File: rtl/key_pkg.sv
// Shared polarity constants and counter-width helper for the key conditioner.
package key_pkg;

  localparam logic KEY_PRESSED  = 1'b1;
  localparam logic KEY_RELEASED = 1'b0;

  // Counter width for a terminal count of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: two-flop synchroniser, debounce, long-press and auto-repeat.
// key_i is already normalised so that 1 means pressed.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 65536,
  parameter int LONG_CYC     = 2**24,
  parameter int REPEAT_CYC   = 2**22
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYC);
  localparam int HW = cnt_width(LONG_CYC + 1);
  localparam int RW = cnt_width(REPEAT_CYC);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYC - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);

  logic          s1_q, s2_q;
  logic          state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= KEY_RELEASED;
      s2_q      <= KEY_RELEASED;
      state_q   <= KEY_RELEASED;
      deb_cnt_q <= '0;
      hold_q    <= '0;
      rep_cnt_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      s1_q      <= key_i;
      s2_q      <= s1_q;
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      hold_q    <= hold_d;
      rep_cnt_q <= rep_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    // Any cycle where s2 agrees with the stable state discards accumulated credit.
    state_d   = state_q;
    deb_cnt_d = '0;
    if (s2_q != state_q) begin
      if (deb_cnt_q == DEB_LAST) state_d = s2_q;
      else                       deb_cnt_d = deb_cnt_q + 1'b1;
    end

    press_d   = (state_d == KEY_PRESSED)  && (state_q == KEY_RELEASED);
    release_d = (state_d == KEY_RELEASED) && (state_q == KEY_PRESSED);

    // Hold time only accrues while pressed and not leaving the pressed state.
    held   = (state_q == KEY_PRESSED) && (state_d == KEY_PRESSED);
    hold_d = '0;
    long_d = 1'b0;
    if (held) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
      long_d = (hold_q == HOLD_PRE);
    end

    rep_cnt_d = '0;
    repeat_d  = 1'b0;
    if (held && (hold_q == HOLD_MAX) && repeat_en_i) begin
      if (rep_cnt_q == REP_LAST) repeat_d = 1'b1;
      else                       rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  assign level_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_array.sv
// N_KEYS independent key channels behind a common input-polarity normalisation.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 65536,
  parameter int LONG_CYC     = 2**24,
  parameter int REPEAT_CYC   = 2**22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  // Active-low pins are inverted so every channel sees 1 = pressed.
  localparam logic POL_FLIP = (ACTIVE_LOW != 0) ? KEY_PRESSED : KEY_RELEASED;

  logic [N_KEYS-1:0] key_pressed;

  assign key_pressed = key_in ^ {N_KEYS{POL_FLIP}};

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_i       (key_pressed[g]),
      .repeat_en_i (repeat_en[g]),
      .level_o     (key_level[g]),
      .press_o     (key_press[g]),
      .release_o   (key_release[g]),
      .long_o      (key_long[g]),
      .repeat_o    (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: active-low and active-high builds checked every
// cycle against a run-length / hold-time reference model, plus directed scenarios.
module tb_key_debounce_array;

  localparam int NK  = 4;
  localparam int NB  = 2;
  localparam int NCH = NK + NB;
  localparam int D   = 8;
  localparam int LC  = 40;
  localparam int RC  = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NK-1:0] key_a, ren_a, lvl_a, prs_a, rel_a, lng_a, rep_a;
  logic [NB-1:0] key_b, ren_b, lvl_b, prs_b, rel_b, lng_b, rep_b;

  key_debounce_array #(
    .N_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYC(D), .LONG_CYC(LC), .REPEAT_CYC(RC)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .key_in(key_a), .repeat_en(ren_a),
    .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a),
    .key_long(lng_a), .key_repeat(rep_a)
  );

  key_debounce_array #(
    .N_KEYS(NB), .ACTIVE_LOW(0), .DEBOUNCE_CYC(D), .LONG_CYC(LC), .REPEAT_CYC(RC)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .key_in(key_b), .repeat_en(ren_b),
    .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b),
    .key_long(lng_b), .key_repeat(rep_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Channels 0..NK-1 belong to dut_a, NK.. to dut_b. Debounce is modelled as the
  // length of the current run of identical synchronised samples.
  logic dl1[NCH], dl2[NCH], mlvl[NCH], rval[NCH];
  logic e_prs[NCH], e_rel[NCH], e_lng[NCH], e_rep[NCH];
  int   rlen[NCH], held_n[NCH], erun[NCH];

  function automatic logic p_of(input int c);
    return (c < NK) ? ~key_a[c] : key_b[c-NK];
  endfunction

  function automatic logic en_of(input int c);
    return (c < NK) ? ren_a[c] : ren_b[c-NK];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      dl1[c] = 1'b0; dl2[c] = 1'b0; mlvl[c] = 1'b0; rval[c] = 1'b0;
      rlen[c] = 0; held_n[c] = 0; erun[c] = 0;
      e_prs[c] = 1'b0; e_rel[c] = 1'b0; e_lng[c] = 1'b0; e_rep[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      logic sv, flip, nl, stay, was_long;
      sv = dl2[c];
      if (sv == rval[c]) rlen[c]++;
      else begin
        rval[c] = sv;
        rlen[c] = 1;
      end
      flip = (sv != mlvl[c]) && (rlen[c] >= D);
      nl   = flip ? sv : mlvl[c];
      e_prs[c] = flip && nl;
      e_rel[c] = flip && !nl;
      stay = mlvl[c] && nl;
      e_lng[c] = 1'b0;
      e_rep[c] = 1'b0;
      if (!stay) begin
        held_n[c] = 0;
        erun[c]   = 0;
      end else begin
        was_long  = (held_n[c] >= LC);
        held_n[c] = held_n[c] + 1;
        e_lng[c]  = (held_n[c] == LC);
        if (was_long && en_of(c)) begin
          erun[c]  = erun[c] + 1;
          e_rep[c] = ((erun[c] % RC) == 0);
        end else begin
          erun[c] = 0;
        end
      end
      dl2[c]  = dl1[c];
      dl1[c]  = p_of(c);
      mlvl[c] = nl;
    end
  endtask

  function automatic logic mval(input int s, input int c);
    case (s)
      0:       return mlvl[c];
      1:       return e_prs[c];
      2:       return e_rel[c];
      3:       return e_lng[c];
      default: return e_rep[c];
    endcase
  endfunction

  function automatic logic [NK-1:0] obs_a(input int s);
    case (s)
      0:       return lvl_a;
      1:       return prs_a;
      2:       return rel_a;
      3:       return lng_a;
      default: return rep_a;
    endcase
  endfunction

  function automatic logic [NB-1:0] obs_b(input int s);
    case (s)
      0:       return lvl_b;
      1:       return prs_b;
      2:       return rel_b;
      3:       return lng_b;
      default: return rep_b;
    endcase
  endfunction

  // Per-channel pulse tallies for dut_a, used by the directed scenarios.
  int cnt_prs[NK], cnt_rel[NK], cnt_lng[NK], cnt_rep[NK], cnt_lvl[NK];
  int t_prs[NK], t_lng[NK], t_rep[NK];

  task automatic clear_tallies();
    for (int c = 0; c < NK; c++) begin
      cnt_prs[c] = 0; cnt_rel[c] = 0; cnt_lng[c] = 0; cnt_rep[c] = 0; cnt_lvl[c] = 0;
      t_prs[c] = 0; t_lng[c] = 0; t_rep[c] = 0;
    end
  endtask

  task automatic compare_all();
    string nm[5] = '{"level", "press", "release", "long", "repeat"};
    for (int s = 0; s < 5; s++) begin
      logic [NK-1:0] ea;
      logic [NB-1:0] eb;
      for (int c = 0; c < NK; c++) ea[c] = mval(s, c);
      for (int c = 0; c < NB; c++) eb[c] = mval(s, NK + c);
      check({"a_", nm[s]}, 32'(obs_a(s)), 32'(ea));
      check({"b_", nm[s]}, 32'(obs_b(s)), 32'(eb));
    end
    check("a_press_and_release", 32'(prs_a & rel_a), 32'd0);
    for (int c = 0; c < NK; c++) begin
      cnt_lvl[c] += int'(lvl_a[c]);
      cnt_rel[c] += int'(rel_a[c]);
      if (prs_a[c]) begin cnt_prs[c]++; t_prs[c] = cyc; end
      if (lng_a[c]) begin cnt_lng[c]++; t_lng[c] = cyc; end
      if (rep_a[c]) begin cnt_rep[c]++; t_rep[c] = cyc; end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs and model are compared there too.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_p(input int c, input logic v);
    if (c < NK) key_a[c] = ~v;
    else        key_b[c-NK] = v;
  endtask

  int tmr[NCH];
  int lat;

  initial begin
    key_a = '1; ren_a = '0;
    key_b = '0; ren_b = '0;
    model_reset();
    clear_tallies();
    #2;
    check("reset_outputs_a", 32'({lvl_a, prs_a, rel_a, lng_a, rep_a}), 32'd0);
    check("reset_outputs_b", 32'({lvl_b, prs_b, rel_b, lng_b, rep_b}), 32'd0);
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(5);

    // Scenario 1: single press, long-press, no repeat.
    clear_tallies();
    set_p(0, 1'b1);
    lat = 0;
    while (!lvl_a[0] && lat < 30) begin cycle(); lat++; end
    check("s1_level_latency", 32'(lat), 32'd10);
    idle(50);
    check("s1_press_count", 32'(cnt_prs[0]), 32'd1);
    check("s1_long_count", 32'(cnt_lng[0]), 32'd1);
    check("s1_long_delay", 32'(t_lng[0] - t_prs[0]), 32'(LC));
    check("s1_repeat_count", 32'(cnt_rep[0]), 32'd0);
    set_p(0, 1'b0);
    idle(20);
    check("s1_release_count", 32'(cnt_rel[0]), 32'd1);

    // Scenario 2: 7-cycle glitches must never qualify.
    clear_tallies();
    repeat (5) begin
      set_p(1, 1'b1); idle(7);
      set_p(1, 1'b0); idle(1);
    end
    idle(20);
    check("s2_level_cycles", 32'(cnt_lvl[1]), 32'd0);
    check("s2_press_count", 32'(cnt_prs[1]), 32'd0);

    // Scenario 3: long hold with repeat enabled, release stops repeats.
    clear_tallies();
    ren_a[2] = 1'b1;
    set_p(2, 1'b1);
    lat = 0;
    while (!lvl_a[2] && lat < 30) begin cycle(); lat++; end
    check("s3_level_latency", 32'(lat), 32'd10);
    idle(65);
    set_p(2, 1'b0);
    idle(30);
    check("s3_long_count", 32'(cnt_lng[2]), 32'd1);
    check("s3_repeat_count", 32'(cnt_rep[2]), 32'd3);
    check("s3_last_repeat_delay", 32'(t_rep[2] - t_lng[2]), 32'(3 * RC));
    check("s3_release_count", 32'(cnt_rel[2]), 32'd1);
    ren_a[2] = 1'b0;

    // Scenario 4: simultaneous presses on channels 0 and 3.
    set_p(0, 1'b1); set_p(3, 1'b1);
    lat = 0;
    while (prs_a == '0 && lat < 30) begin cycle(); lat++; end
    check("s4_press_vector", 32'(prs_a), 32'b1001);
    set_p(0, 1'b0); set_p(3, 1'b0);
    idle(20);

    // Scenario 5: reset while key 0 is held yields a fresh press afterwards.
    set_p(0, 1'b1);
    idle(20);
    rst_n = 1'b0;
    #1;
    check("s5_outputs_in_reset", 32'({lvl_a, prs_a, rel_a, lng_a, rep_a}), 32'd0);
    @(negedge clk);
    idle(3);
    rst_n = 1'b1;
    lat = 0;
    while (!prs_a[0] && lat < 30) begin cycle(); lat++; end
    check("s5_press_after_reset", 32'(lat), 32'd10);
    set_p(0, 1'b0);
    idle(20);

    // Scenario 6: active-high build.
    set_p(NK, 1'b1);
    lat = 0;
    while (!prs_b[0] && lat < 30) begin cycle(); lat++; end
    check("s6_press_latency", 32'(lat), 32'd10);
    check("s6_level", 32'(lvl_b[0]), 32'd1);
    set_p(NK, 1'b0);
    lat = 0;
    while (!rel_b[0] && lat < 30) begin cycle(); lat++; end
    check("s6_release_latency", 32'(lat), 32'd10);
    idle(5);

    // Randomised phase: mixed glitches and long holds on every channel.
    for (int c = 0; c < NCH; c++) tmr[c] = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (tmr[c] == 0) begin
          set_p(c, 1'($urandom_range(0, 1)));
          tmr[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9)
                                                : $urandom_range(10, 90);
        end
        tmr[c]--;
      end
      if ($urandom_range(0, 49) == 0) begin
        ren_a = 4'($urandom);
        ren_b = 2'($urandom);
      end
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
